// File: rtl/filter_rd_pkg.sv
// Shared types and default constants for the filter serial reader.
package filter_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD
  } rd_state_t;

  localparam int unsigned RD_DATA_W   = 12;
  localparam int unsigned RD_SCLK_DIV = 1;
  localparam int unsigned RD_CS_SETUP = 2;
  localparam int unsigned RD_CS_HOLD  = 1;

endpackage

// File: rtl/filter_rd_phase_cnt.sv
// Loadable down-counter timing each reader phase; done flags the last cycle.
module filter_rd_phase_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/filter_serial_reader.sv
// Host-side reader: on a falling edge of new_data, runs one cs_n-framed
// transfer and shifts in DATA_W bits MSB-first from the filter.
module filter_serial_reader
  import filter_rd_pkg::*;
#(
  parameter int unsigned DATA_W   = RD_DATA_W,
  parameter int unsigned SCLK_DIV = RD_SCLK_DIV,
  parameter int unsigned CS_SETUP = RD_CS_SETUP,
  parameter int unsigned CS_HOLD  = RD_CS_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              new_data,
  input  logic              serial_data_in,
  output logic              sclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned PH_MAX0 = (CS_SETUP > SCLK_DIV) ? CS_SETUP : SCLK_DIV;
  localparam int unsigned PH_MAX  = (PH_MAX0 > CS_HOLD) ? PH_MAX0 : CS_HOLD;
  localparam int unsigned PH_W    = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);
  localparam int unsigned BC_W    = $clog2(DATA_W + 1);

  // Phase counter is loaded with duration-1 so done lands on the last cycle.
  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] PH_HALF  = PH_W'(SCLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HOLD  = PH_W'(CS_HOLD - 1);
  localparam logic [BC_W-1:0] BITS     = BC_W'(DATA_W);

  rd_state_t         state, state_d;
  logic              nd_q;
  logic              trigger;
  logic              ph_load;
  logic [PH_W-1:0]   ph_val;
  logic              ph_done;
  logic              shift_en;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;

  assign trigger = nd_q & ~new_data;

  filter_rd_phase_cnt #(
    .W(PH_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ph_load),
    .load_val(ph_val),
    .done    (ph_done)
  );

  // Next-state logic; each transition reloads the phase counter.
  always_comb begin
    state_d  = state;
    ph_load  = 1'b0;
    ph_val   = '0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && enable) begin
          state_d = SETUP;
          ph_load = 1'b1;
          ph_val  = PH_SETUP;
        end
      end
      SETUP: begin
        if (ph_done) begin
          state_d = SHIFT_LO;
          ph_load = 1'b1;
          ph_val  = PH_HALF;
        end
      end
      SHIFT_LO: begin
        if (ph_done) begin
          state_d  = SHIFT_HI;
          ph_load  = 1'b1;
          ph_val   = PH_HALF;
          shift_en = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (ph_done) begin
          ph_load = 1'b1;
          if (bit_cnt == BITS) begin
            state_d = HOLD;
            ph_val  = PH_HOLD;
          end else begin
            state_d = SHIFT_LO;
            ph_val  = PH_HALF;
          end
        end
      end
      HOLD: begin
        if (ph_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and new_data edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      nd_q  <= 1'b0;
    end else begin
      state <= state_d;
      nd_q  <= new_data;
    end
  end

  // Outputs decoded from the next state so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sclk    <= (state_d == SHIFT_HI);
      cs_n    <= (state_d == IDLE);
      busy    <= (state_d != IDLE);
      overrun <= trigger && (state != IDLE);
    end
  end

  // Shift on the sclk-rising edge; bit count restarts on entry to SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && state_d == SETUP) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[DATA_W-2:0], serial_data_in};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Publish the word and pulse valid on the HOLD -> IDLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == HOLD) && (state_d == IDLE);
      if ((state == HOLD) && (state_d == IDLE)) begin
        data_out <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_filter_serial_reader.sv
// Self-checking bench for filter_serial_reader (default and SCLK_DIV=3 builds).
module tb_filter_serial_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        new_data0 = 1'b0;
  logic        new_data3 = 1'b0;
  logic        sdi0, sdi3;
  logic        sclk0, sclk3, cs_n0, cs_n3;
  logic [11:0] data_out0, data_out3;
  logic        data_valid0, data_valid3, busy0, busy3, overrun0, overrun3;

  logic [11:0] word0 = 12'h000;
  logic [11:0] word3 = 12'h000;
  logic [3:0]  idx0 = 4'd11;
  logic [3:0]  idx3 = 4'd11;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  filter_serial_reader u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .new_data(new_data0),
    .serial_data_in(sdi0), .sclk(sclk0), .cs_n(cs_n0), .data_out(data_out0),
    .data_valid(data_valid0), .busy(busy0), .overrun(overrun0)
  );

  filter_serial_reader #(.SCLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .new_data(new_data3),
    .serial_data_in(sdi3), .sclk(sclk3), .cs_n(cs_n3), .data_out(data_out3),
    .data_valid(data_valid3), .busy(busy3), .overrun(overrun3)
  );

  // Filter models: MSB presented at cs_n fall, next bit after each sclk rise.
  assign sdi0 = word0[idx0];
  assign sdi3 = word3[idx3];

  always @(negedge cs_n0 or posedge sclk0) begin
    if (sclk0) begin
      if (idx0 != 4'd0) idx0 = idx0 - 4'd1;
    end else begin
      idx0 = 4'd11;
    end
  end

  always @(negedge cs_n3 or posedge sclk3) begin
    if (sclk3) begin
      if (idx3 != 4'd0) idx3 = idx3 - 4'd1;
    end else begin
      idx3 = 4'd11;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic set_nd(input bit sel, input logic v);
    if (sel) new_data3 = v;
    else     new_data0 = v;
  endtask

  // Trigger one frame and observe window cycles (sampled on negedges).
  task automatic run_frame(input bit sel, input logic [11:0] w, input logic en,
                           input int drop_at, input int retrig_at, input int window,
                           output int cs_low, output int rises, output int hi_cyc,
                           output int lat, output int vcnt, output int ovr,
                           output logic [11:0] dout);
    logic prev;
    if (sel) word3 = w;
    else     word0 = w;
    enable = en;
    cs_low = 0; rises = 0; hi_cyc = 0; lat = 0; vcnt = 0; ovr = 0;
    dout = sel ? data_out3 : data_out0;
    @(negedge clk); set_nd(sel, 1'b1);
    @(negedge clk); set_nd(sel, 1'b0);
    prev = 1'b0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (!(sel ? cs_n3 : cs_n0)) cs_low++;
      if (sel ? sclk3 : sclk0) begin
        hi_cyc++;
        if (!prev) rises++;
      end
      prev = sel ? sclk3 : sclk0;
      if (sel ? data_valid3 : data_valid0) begin
        vcnt++;
        if (lat == 0) lat = k;
        dout = sel ? data_out3 : data_out0;
      end
      if (sel ? overrun3 : overrun0) ovr++;
      if (k == drop_at) enable = 1'b0;
      if (k == retrig_at - 1) set_nd(sel, 1'b1);
      if (k == retrig_at) set_nd(sel, 1'b0);
    end
    enable = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [11:0] word;
    logic [11:0] exp_data;
    int          exp_valid;
    int          exp_cs_low;
    int          exp_rises;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cs_low, rises, hi_cyc, lat, vcnt, ovr, ovr_tot;
    logic [11:0] dout, w;
    logic prev;

    vecs[0] = '{1'b1, 12'hA5C, 12'hA5C, 1, 27, 12, 28};
    vecs[1] = '{1'b1, 12'h000, 12'h000, 1, 27, 12, 28};
    vecs[2] = '{1'b1, 12'hFFF, 12'hFFF, 1, 27, 12, 28};
    vecs[3] = '{1'b0, 12'h3C3, 12'hFFF, 0,  0,  0,  0};
    vecs[4] = '{1'b1, 12'h800, 12'h800, 1, 27, 12, 28};
    vecs[5] = '{1'b1, 12'h001, 12'h001, 1, 27, 12, 28};
    vecs[6] = '{1'b1, 12'h5A5, 12'h5A5, 1, 27, 12, 28};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs_n", int'(cs_n0), 1);
    chk("rst_sclk", int'(sclk0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_valid", int'(data_valid0), 0);
    chk("rst_overrun", int'(overrun0), 0);
    chk("rst_data", int'(data_out0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames on the default build
    for (int i = 0; i < 7; i++) begin
      run_frame(1'b0, vecs[i].word, vecs[i].en, 0, 0, 40,
                cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
      chk($sformatf("v%0d_data", i), int'(dout), int'(vecs[i].exp_data));
      chk($sformatf("v%0d_valid_cnt", i), vcnt, vecs[i].exp_valid);
      chk($sformatf("v%0d_cs_low", i), cs_low, vecs[i].exp_cs_low);
      chk($sformatf("v%0d_rises", i), rises, vecs[i].exp_rises);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_overrun", i), ovr, 0);
    end

    // SCLK_DIV=3: 3-cycle phases, data holds between transfers
    run_frame(1'b1, 12'h001, 1'b1, 0, 0, 90, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
    chk("d3a_data", int'(dout), 12'h001);
    chk("d3a_cs_low", cs_low, 75);
    chk("d3a_rises", rises, 12);
    chk("d3a_hi_cycles", hi_cyc, 36);
    chk("d3a_latency", lat, 76);
    chk("d3a_valid_cnt", vcnt, 1);
    repeat (10) @(negedge clk);
    chk("d3_hold", int'(data_out3), 12'h001);
    run_frame(1'b1, 12'hFFF, 1'b1, 0, 0, 90, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
    chk("d3b_data", int'(dout), 12'hFFF);
    chk("d3b_hi_cycles", hi_cyc, 36);
    chk("d3b_overrun", ovr, 0);

    // Retrigger 10 cycles into a transfer
    run_frame(1'b0, 12'h6E1, 1'b1, 0, 10, 60, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
    chk("ovr_pulses", ovr, 1);
    chk("ovr_data", int'(dout), 12'h6E1);
    chk("ovr_valid_cnt", vcnt, 1);
    chk("ovr_cs_low", cs_low, 27);
    chk("ovr_rises", rises, 12);

    // enable dropped mid-transfer
    run_frame(1'b0, 12'h39B, 1'b1, 5, 0, 40, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
    chk("endrop_data", int'(dout), 12'h39B);
    chk("endrop_valid_cnt", vcnt, 1);
    chk("endrop_latency", lat, 28);

    // Asynchronous reset at bit 5
    word0 = 12'hC3A;
    @(negedge clk); new_data0 = 1'b1;
    @(negedge clk); new_data0 = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int k = 0; k < 60 && rises < 5; k++) begin
      @(posedge clk); #1;
      if (sclk0 && !prev) rises++;
      prev = sclk0;
    end
    chk("rstmid_reached_bit5", rises, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", int'(cs_n0), 1);
    chk("rstmid_sclk", int'(sclk0), 0);
    chk("rstmid_data", int'(data_out0), 0);
    chk("rstmid_busy", int'(busy0), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 12'hC3A, 1'b1, 0, 0, 40, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
    chk("rstmid_next_data", int'(dout), 12'hC3A);
    chk("rstmid_next_valid", vcnt, 1);

    // Random frames with random gaps after busy falls
    ovr_tot = 0;
    for (int i = 0; i < 200; i++) begin
      w = 12'($urandom_range(0, 4095));
      run_frame(1'b0, w, 1'b1, 0, 0, 29, cs_low, rises, hi_cyc, lat, vcnt, ovr, dout);
      chk($sformatf("rand%0d_data", i), int'(dout), int'(w));
      ovr_tot += ovr;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("rand_overruns", ovr_tot, 0);
    chk("end_busy0", int'(busy0), 0);
    chk("end_busy3", int'(busy3), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
